// File: rtl/s_arbiter.sv
// s_arbiter: round-robin per-slave arbiter with read-ID return FIFO; S_ARB_PROT_ERR_EN adds sticky prot_err.
// Latency: m_req sampled at edge k drives s_req after edge k; m_ack/m_resp/m_rdata are combinational.
// Backpressure: one request in flight until s_ack; no new grant while the read-ID FIFO is full.
module s_arbiter #(
  parameter int N_M      = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_M-1:0]    m_req,
  input  logic [N_M*AW-1:0] m_addr,
  input  logic [N_M-1:0]    m_cmd,
  input  logic [N_M*DW-1:0] m_wdata,
  output logic [N_M-1:0]    m_ack,
  output logic [N_M-1:0]    m_resp,
  output logic [DW-1:0]     m_rdata,
  output logic [N_M-1:0]    req_sent,
  output logic [N_M-1:0]    data_read,
  output logic              s_req,
  output logic [AW-1:0]     s_addr,
  output logic              s_cmd,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DW-1:0]     s_rdata
`ifdef S_ARB_PROT_ERR_EN
  ,output logic             prot_err
`endif
);

  localparam int GW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          cmd;
    logic [DW-1:0] wdata;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [GW-1:0]   grant_q, last_grant_q, rr_pick;
  logic            rr_found;
  logic [N_M-1:0]  req_sent_q;
  logic [GW-1:0]   rid_mem [RQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            fifo_full, fifo_empty, do_grant, ack_ok, push, pop;

  function automatic logic [N_M-1:0] onehot(input logic [GW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan starts one past the previous winner so every requester is served in turn.
  always_comb begin
    logic [GW-1:0] cand;
    rr_found = 1'b0;
    rr_pick  = '0;
    cand     = '0;
    for (int off = 1; off <= N_M; off++) begin
      cand = GW'((int'(last_grant_q) + off) % N_M);
      if (!rr_found && m_req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign fifo_full  = (count_q == CW'(RQ_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign ack_ok     = s_ack && (state_q == BUSY) && !rst;
  assign push       = ack_ok && !req_q.cmd;
  assign pop        = s_resp && !fifo_empty && !rst;
  assign do_grant   = (state_q == IDLE) && rr_found && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_grant) state_d = BUSY;
      BUSY:    if (s_ack)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_req     = (state_q == BUSY);
  assign s_addr    = req_q.addr;
  assign s_cmd     = req_q.cmd;
  assign s_wdata   = req_q.wdata;
  assign req_sent  = req_sent_q;
  assign m_ack     = ack_ok ? onehot(grant_q) : '0;
  assign m_resp    = pop ? onehot(rid_mem[rd_ptr_q]) : '0;
  assign data_read = m_resp;
  assign m_rdata   = pop ? s_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(N_M - 1);
      req_sent_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      req_sent_q <= '0;
      if (do_grant) begin
        grant_q     <= rr_pick;
        req_q.addr  <= m_addr[int'(rr_pick)*AW +: AW];
        req_q.cmd   <= m_cmd[rr_pick];
        req_q.wdata <= m_wdata[int'(rr_pick)*DW +: DW];
        req_sent_q  <= onehot(rr_pick);
      end
      if (ack_ok) last_grant_q <= grant_q;
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) rid_mem[wr_ptr_q] <= grant_q;
  end

`ifdef S_ARB_PROT_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      prot_err <= 1'b0;
    else if ((s_resp && fifo_empty) || (s_ack && state_q == IDLE))
      prot_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_s_arbiter.sv
// Testbench for s_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_s_arbiter;
  localparam int N_M = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int D   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_M-1:0]    m_req, m_cmd, m_ack, m_resp, req_sent, data_read;
  logic [N_M*AW-1:0] m_addr;
  logic [N_M*DW-1:0] m_wdata;
  logic [DW-1:0]     m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]     s_addr;
  logic              s_req, s_cmd, s_ack, s_resp;
`ifdef S_ARB_PROT_ERR_EN
  logic              prot_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s_arbiter #(.N_M(N_M), .AW(AW), .DW(DW), .RQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .req_sent(req_sent), .data_read(data_read),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
`ifdef S_ARB_PROT_ERR_EN
    , .prot_err(prot_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req got %b exp 0", s_req); end
    checks++; if (s_addr !== '0) begin errors++; $display("FAIL reset_s_addr got %h exp 0", s_addr); end
    checks++; if (req_sent !== '0) begin errors++; $display("FAIL reset_req_sent got %b exp 00", req_sent); end
    checks++; if (m_ack !== '0 || m_resp !== '0 || data_read !== '0) begin
      errors++; $display("FAIL reset_pulses got ack=%b resp=%b dr=%b exp 0", m_ack, m_resp, data_read); end
    checks++; if (m_rdata !== '0) begin errors++; $display("FAIL reset_m_rdata got %h exp 0", m_rdata); end
`ifdef S_ARB_PROT_ERR_EN
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot_err got %b exp 0", prot_err); end
`endif
  endtask

  task automatic test_write_ack();
    do_reset();
    m_req = 2'b01; m_cmd = 2'b01;
    m_addr[0 +: AW] = 32'h10; m_wdata[0 +: DW] = 32'hDEADBEEF;
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL wr_s_req got %b exp 1", s_req); end
    checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL wr_s_addr got %h exp 10", s_addr); end
    checks++; if (s_cmd !== 1'b1 || s_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_fields got cmd=%b wdata=%h exp 1 deadbeef", s_cmd, s_wdata); end
    checks++; if (req_sent !== 2'b01) begin errors++; $display("FAIL wr_req_sent got %b exp 01", req_sent); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL wr_no_ack got %b exp 00", m_ack); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL wr_m_ack got %b exp 01", m_ack); end
    tick();
    s_ack = 1'b0; m_req = '0;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL wr_s_req_drop got %b exp 0", s_req); end
    checks++; if (req_sent !== 2'b00) begin errors++; $display("FAIL wr_req_sent_pulse got %b exp 00", req_sent); end
  endtask

  task automatic test_round_robin();
    logic [N_M-1:0] exp;
    int g;
    do_reset();
    m_req = 2'b11; m_cmd = 2'b11;
    m_addr = {32'h0000_0B00, 32'h0000_0A00};
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      exp = '0; exp[g] = 1'b1;
      tick();
      checks++; if (s_req !== 1'b1 || req_sent !== exp) begin
        errors++; $display("FAIL rr_grant%0d got s_req=%b req_sent=%b exp 1 %b", i, s_req, req_sent, exp); end
      checks++; if (s_addr !== (g == 0 ? 32'h0A00 : 32'h0B00)) begin
        errors++; $display("FAIL rr_addr%0d got %h exp master %0d addr", i, s_addr, g); end
      s_ack = 1'b1;
      #1;
      checks++; if (m_ack !== exp) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", i, m_ack, exp); end
      tick();
      s_ack = 1'b0;
    end
    m_req = '0;
  endtask

  task automatic test_read_return();
    do_reset();
    m_req = 2'b10; m_cmd = 2'b00; m_addr[AW +: AW] = 32'h20;
    tick();
    checks++; if (s_req !== 1'b1 || s_cmd !== 1'b0 || req_sent !== 2'b10) begin
      errors++; $display("FAIL rd_grant got s_req=%b cmd=%b req_sent=%b exp 1 0 10", s_req, s_cmd, req_sent); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rd_ack got %b exp 10", m_ack); end
    tick();
    s_ack = 1'b0; m_req = '0;
    s_resp = 1'b1; s_rdata = 32'hCAFE;
    #1;
    checks++; if (m_resp !== 2'b10 || data_read !== 2'b10) begin
      errors++; $display("FAIL rd_resp got resp=%b dr=%b exp 10 10", m_resp, data_read); end
    checks++; if (m_rdata !== 32'hCAFE) begin errors++; $display("FAIL rd_rdata got %h exp cafe", m_rdata); end
    tick();
    s_resp = 1'b0;
    #1;
    checks++; if (m_rdata !== '0 || m_resp !== '0) begin
      errors++; $display("FAIL rd_idle got rdata=%h resp=%b exp 0 00", m_rdata, m_resp); end
    s_resp = 1'b1; s_rdata = 32'h1234;
    #1;
    checks++; if (m_resp !== '0 || data_read !== '0 || m_rdata !== '0) begin
      errors++; $display("FAIL rd_stray got resp=%b dr=%b rdata=%h exp 0", m_resp, data_read, m_rdata); end
    tick();
    s_resp = 1'b0;
`ifdef S_ARB_PROT_ERR_EN
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL rd_prot_err got %b exp 1", prot_err); end
`endif
  endtask

  task automatic test_fifo_full();
    int order [4] = '{1, 0, 1, 0};
    logic [N_M-1:0] exp;
    do_reset();
    m_req = 2'b11; m_cmd = 2'b00;
    for (int i = 0; i < D; i++) begin
      tick();
      exp = '0; exp[i % 2] = 1'b1;
      checks++; if (s_req !== 1'b1 || req_sent !== exp) begin
        errors++; $display("FAIL full_fill%0d got s_req=%b req_sent=%b exp 1 %b", i, s_req, req_sent, exp); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_req !== 1'b0 || req_sent !== '0) begin
        errors++; $display("FAIL full_stall%0d got s_req=%b req_sent=%b exp 0 00", i, s_req, req_sent); end
      tick();
    end
    s_resp = 1'b1; s_rdata = 32'h55;
    #1;
    checks++; if (m_resp !== 2'b01 || m_rdata !== 32'h55) begin
      errors++; $display("FAIL full_pop got resp=%b rdata=%h exp 01 55", m_resp, m_rdata); end
    tick();
    s_resp = 1'b0;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_pop_edge got s_req=%b exp 0", s_req); end
    tick();
    checks++; if (s_req !== 1'b1 || req_sent !== 2'b01) begin
      errors++; $display("FAIL full_resume got s_req=%b req_sent=%b exp 1 01", s_req, req_sent); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
    for (int i = 0; i < 4; i++) begin
      s_resp = 1'b1; s_rdata = DW'(i + 100);
      exp = '0; exp[order[i]] = 1'b1;
      #1;
      checks++; if (m_resp !== exp || m_rdata !== DW'(i + 100)) begin
        errors++; $display("FAIL full_drain%0d got resp=%b rdata=%h exp %b %h", i, m_resp, m_rdata, exp, i + 100); end
      tick();
    end
    s_resp = 1'b0;
  endtask

  task automatic test_push_pop();
    do_reset();
    m_req = 2'b01; m_cmd = 2'b00;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = 2'b10;
    tick();
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hBEEF;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL pp_ack got %b exp 10", m_ack); end
    checks++; if (m_resp !== 2'b01 || m_rdata !== 32'hBEEF) begin
      errors++; $display("FAIL pp_pop got resp=%b rdata=%h exp 01 beef", m_resp, m_rdata); end
    tick();
    s_ack = 1'b0; s_resp = 1'b0; m_req = '0;
    tick();
    s_resp = 1'b1; s_rdata = 32'h77;
    #1;
    checks++; if (m_resp !== 2'b10) begin errors++; $display("FAIL pp_new_head got %b exp 10", m_resp); end
    tick();
    #1;
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL pp_empty got %b exp 00", m_resp); end
    tick();
    s_resp = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    m_req = 2'b01; m_cmd = 2'b00; m_addr[0 +: AW] = 32'h44;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = 2'b10;
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rb_busy got %b exp 1", s_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; m_req = '0;
    checks++; if (s_req !== 1'b0 || s_addr !== '0) begin
      errors++; $display("FAIL rb_s_req got s_req=%b addr=%h exp 0 0", s_req, s_addr); end
`ifdef S_ARB_PROT_ERR_EN
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL rb_prot_clear got %b exp 0", prot_err); end
`endif
    s_resp = 1'b1; s_rdata = 32'h99;
    #1;
    checks++; if (m_resp !== '0 || data_read !== '0) begin
      errors++; $display("FAIL rb_fifo_flushed got resp=%b dr=%b exp 0", m_resp, data_read); end
    tick();
    s_resp = 1'b0;
`ifdef S_ARB_PROT_ERR_EN
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL rb_prot_set got %b exp 1", prot_err); end
`endif
    m_req = 2'b11; m_cmd = 2'b11;
    tick();
    checks++; if (req_sent !== 2'b01) begin errors++; $display("FAIL rb_first_grant got %b exp 01", req_sent); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
  endtask

  // Transaction-level model: pending reads are a queue of master IDs; grants follow round-robin order.
  task automatic test_random();
    int last_g, g, size0;
    int q[$];
    bit busy, just, pop, found;
    logic [AW-1:0]  e_addr;
    logic           e_cmd;
    logic [DW-1:0]  e_wdata;
    logic [N_M-1:0] acked, exp;
    do_reset();
    last_g = N_M - 1; g = 0; busy = 0; just = 0; acked = '0;
    e_addr = '0; e_cmd = 1'b0; e_wdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp = '0; if (just) exp[g] = 1'b1;
      checks++; if (s_req !== busy) begin
        errors++; $display("FAIL rnd_s_req cyc %0d got %b exp %b", cyc, s_req, busy); end
      checks++; if (req_sent !== exp) begin
        errors++; $display("FAIL rnd_req_sent cyc %0d got %b exp %b", cyc, req_sent, exp); end
      if (busy) begin
        checks++; if (s_addr !== e_addr || s_cmd !== e_cmd || s_wdata !== e_wdata) begin
          errors++; $display("FAIL rnd_fields cyc %0d got %h %b %h exp %h %b %h",
                             cyc, s_addr, s_cmd, s_wdata, e_addr, e_cmd, e_wdata); end
      end
      for (int i = 0; i < N_M; i++) begin
        if (acked[i]) m_req[i] = 1'b0;
        else if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i] = 1'b1;
          m_cmd[i] = 1'($urandom_range(0, 1));
          m_addr[i*AW +: AW]  = $urandom;
          m_wdata[i*DW +: DW] = $urandom;
        end
      end
      acked   = '0;
      s_ack   = busy && ($urandom_range(0, 1) == 1);
      s_resp  = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      #1;
      exp = '0; if (s_ack) exp[g] = 1'b1;
      checks++; if (m_ack !== exp) begin
        errors++; $display("FAIL rnd_m_ack cyc %0d got %b exp %b", cyc, m_ack, exp); end
      pop = s_resp && (q.size() > 0);
      exp = '0; if (pop) exp[q[0]] = 1'b1;
      checks++; if (m_resp !== exp || data_read !== exp) begin
        errors++; $display("FAIL rnd_resp cyc %0d got resp=%b dr=%b exp %b", cyc, m_resp, data_read, exp); end
      checks++; if (m_rdata !== (pop ? s_rdata : '0)) begin
        errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, m_rdata, pop ? s_rdata : '0); end
      size0 = q.size();
      just = 0;
      if (pop) void'(q.pop_front());
      if (busy) begin
        if (s_ack) begin
          if (!e_cmd) q.push_back(g);
          last_g = g; busy = 0; acked[g] = 1'b1;
        end
      end else if (m_req != '0 && size0 < D) begin
        found = 0;
        for (int off = 1; off <= N_M; off++) begin
          if (!found && m_req[(last_g + off) % N_M]) begin
            g = (last_g + off) % N_M; found = 1;
          end
        end
        busy = 1; just = 1;
        e_addr = m_addr[g*AW +: AW]; e_cmd = m_cmd[g]; e_wdata = m_wdata[g*DW +: DW];
      end
      tick();
    end
    s_ack = 1'b0; s_resp = 1'b0; m_req = '0;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_round_robin();
    test_read_return();
    test_fifo_full();
    test_push_pop();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
